// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed hex scanner feeding a seven-segment decoder.
// Define HEX_SCAN_LZB_EN to enable leading-zero blanking.
module hex_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_en,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   dp_sel,
    input  logic                    blank_all,
    output logic [3:0]              dec_value,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    dp_n,
    output logic                    scan_tick
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] shadow_data_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [3:0]              dec_value_r;
    logic [NUM_DIGITS-1:0]   digit_en_n_r;
    logic                    dp_n_r;
    logic                    terminal_s;
    logic                    blank_s;
    logic [3:0]              nibble_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic                    dp_bit_s;

    assign terminal_s = (cnt_r == CNT_LAST);

`ifdef HEX_SCAN_LZB_EN
    // Highest nonzero nibble position; a zero word reports digit 0.
    function automatic logic [IDX_W-1:0] find_msd(input logic [4*NUM_DIGITS-1:0] word);
        logic [IDX_W-1:0] msd;
        msd = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (word[4*i +: 4] != 4'h0) begin
                msd = IDX_W'(i);
            end else begin
                msd = msd;
            end
        end
        return msd;
    endfunction

    assign blank_s = blank_all | (idx_r > find_msd(shadow_data_r));
`else
    assign blank_s = blank_all;
`endif

    // Refresh counter and digit index; blanking never pauses the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (terminal_s) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            idx_r <= idx_r;
        end
    end

    // Shadow capture of the display word and decimal points.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r   <= {NUM_DIGITS{1'b0}};
        end else if (load_en) begin
            shadow_data_r <= load_data;
            shadow_dp_r   <= dp_sel;
        end else begin
            shadow_data_r <= shadow_data_r;
            shadow_dp_r   <= shadow_dp_r;
        end
    end

    // Select the current digit's nibble, one-hot enable and decimal point.
    always_comb begin
        nibble_s = 4'h0;
        onehot_s = {NUM_DIGITS{1'b0}};
        dp_bit_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                nibble_s    = shadow_data_r[4*i +: 4];
                onehot_s[i] = 1'b1;
                dp_bit_s    = shadow_dp_r[i];
            end else begin
                onehot_s[i] = 1'b0;
            end
        end
    end

    // Registered output stage; the nibble still flows while the digit is dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_value_r  <= 4'h0;
            digit_en_n_r <= {NUM_DIGITS{1'b1}};
            dp_n_r       <= 1'b1;
        end else begin
            dec_value_r  <= nibble_s;
            digit_en_n_r <= blank_s ? {NUM_DIGITS{1'b1}} : ~onehot_s;
            dp_n_r       <= blank_s ? 1'b1 : ~dp_bit_s;
        end
    end

    assign dec_value  = dec_value_r;
    assign digit_en_n = digit_en_n_r;
    assign dp_n       = dp_n_r;
    assign scan_tick  = terminal_s;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Scoreboard bench for hex_scan_driver (8 digits, 4 cycles per digit).
module tb_hex_scan_driver;
`ifdef HEX_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        load_en   = 1'b0;
    logic [31:0] load_data = 32'h0;
    logic [7:0]  dp_sel    = 8'h00;
    logic        blank_all = 1'b0;
    logic [3:0]  dec_value;
    logic [7:0]  digit_en_n;
    logic        dp_n;
    logic        scan_tick;

    typedef struct {
        string      name;
        logic [3:0] dv;
        logic [7:0] en;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    logic [31:0] exp_word = 32'h0;
    logic [7:0]  exp_dpw = 8'h00;
    int          exp_msd = 0;
    bit          exp_blank = 1'b0;
    string       phase = "init";

    always #5 clk = ~clk;

    hex_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .load_data  (load_data),
        .dp_sel     (dp_sel),
        .blank_all  (blank_all),
        .dec_value  (dec_value),
        .digit_en_n (digit_en_n),
        .dp_n       (dp_n),
        .scan_tick  (scan_tick)
    );

    // Monitor: compare outputs against the oldest expectation on each falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (dec_value !== e.dv || digit_en_n !== e.en || dp_n !== e.dp || scan_tick !== e.tick) begin
                errors++;
                $display("FAIL %s: got dv=%h en=%h dp=%b tick=%b, want dv=%h en=%h dp=%b tick=%b",
                         e.name, dec_value, digit_en_n, dp_n, scan_tick, e.dv, e.en, e.dp, e.tick);
            end
        end
    end

    task automatic push_exp(input string nm, input logic [3:0] dv, input logic [7:0] en,
                            input logic dp, input logic tk);
        exp_t e;
        e.name = nm; e.dv = dv; e.en = en; e.dp = dp; e.tick = tk;
        sb_q.push_back(e);
    endtask

    // Expected outputs after edge k since reset release: digit (k-1)/4 is shown.
    task automatic push_model();
        exp_t e;
        int   i;
        bit   dark;
        i      = ((k - 1) / 4) % 8;
        dark   = exp_blank || (LZB && (i > exp_msd));
        e.name = $sformatf("%s k=%0d", phase, k);
        e.dv   = exp_word[4*i +: 4];
        e.en   = dark ? 8'hFF : ~(8'h01 << i);
        e.dp   = dark ? 1'b1 : ~exp_dpw[i];
        e.tick = ((k % 4) == 3);
        sb_q.push_back(e);
    endtask

    task automatic step(input bit chk);
        @(posedge clk);
        #1;
        k++;
        if (chk) push_model();
    endtask

    initial begin
        step(1'b0);
        step(1'b0);
        push_exp("reset_init", 4'h0, 8'hFF, 1'b1, 1'b0);
        step(1'b0);

        // Release reset and load the full-scan word in the same cycle.
        rst_n = 1'b1; load_en = 1'b1; load_data = 32'h1234ABCD; dp_sel = 8'h00;
        k = 0; phase = "first_edge";
        step(1'b1);
        load_en = 1'b0; exp_word = 32'h1234ABCD; phase = "full_scan";
        while (k < 33) step(1'b1);

        // Run on to idx=5 then reset asynchronously between edges.
        while (k < 52) step(1'b0);
        rst_n = 1'b0;
        push_exp("reset_mid_scan", 4'h0, 8'hFF, 1'b1, 1'b0);
        step(1'b0);
        rst_n = 1'b1; k = 0; exp_word = 32'h0; exp_dpw = 8'h00; exp_msd = 0; phase = "rst_release";
        step(1'b1);

        // Leading-zero word.
        load_en = 1'b1; load_data = 32'h000000A0; dp_sel = 8'h00; phase = "lzb_load";
        step(1'b1);
        load_en = 1'b0; exp_word = 32'h000000A0; exp_msd = 1; phase = "lzb";
        while (k < 33) step(1'b1);

        // Zero word with decimal points on digits 0 and 7.
        load_en = 1'b1; load_data = 32'h0; dp_sel = 8'h81; phase = "zero_dp_load";
        step(1'b1);
        load_en = 1'b0; exp_word = 32'h0; exp_dpw = 8'h81; exp_msd = 0; phase = "zero_dp";
        while (k < 66) step(1'b1);

        // Load coinciding with terminal count at idx=2 (after edge 75: cnt=3, idx=2).
        while (k < 75) step(1'b0);
        load_en = 1'b1; load_data = 32'hFFFFFFFF; dp_sel = 8'h00; phase = "load_tc_old";
        step(1'b1);
        load_en = 1'b0; exp_word = 32'hFFFFFFFF; exp_dpw = 8'h00; exp_msd = 7; phase = "load_tc";
        while (k < 80) step(1'b1);

        // Blank for six cycles starting at idx=1, cnt=0 (after edge 100).
        while (k < 100) step(1'b0);
        blank_all = 1'b1; exp_blank = 1'b1; phase = "blank";
        repeat (6) step(1'b1);
        blank_all = 1'b0; exp_blank = 1'b0; phase = "unblank";
        step(1'b1);
        step(1'b1);

        for (int n = 0; n < 5; n++) begin
            if (sb_q.size() > 0) step(1'b0);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_scan_driver.md
# hex_scan_driver

Time-multiplexed scanner that drives an NUM_DIGITS-digit common-anode seven-segment display from a captured hex word. It sits directly upstream of the per-digit seven-segment decoder. Each refresh slot it presents one 4-bit nibble on `dec_value`, which the decoder turns into segment patterns. It also drives the one-hot active-low digit enables and the decimal point.

## Interface
Parameters:
- `NUM_DIGITS`, 8: digits scanned; legal 1..8.
- `REFRESH_DIV`, 50000: clock cycles each digit stays lit; legal >= 1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `load_en`  in  1  capture `load_data` and `dp_sel` this cycle.
- `load_data`  in  4*NUM_DIGITS  hex word; nibble i (bits 4i+3:4i) shown on digit i; digit 0 is rightmost.
- `dp_sel`  in  NUM_DIGITS  per-digit decimal point request, active-high.
- `blank_all`  in  1  forces every digit off while high.
- `dec_value`  out  4  nibble for the current digit; connects to the decoder's `dec_value`.
- `digit_en_n`  out  NUM_DIGITS  active-low one-hot anode enables.
- `dp_n`  out  1  active-low decimal point for the current digit.
- `scan_tick`  out  1  one-cycle pulse when the digit index advances.

## Operation
- Shadow registers `shadow_data` and `shadow_dp` load on any cycle with `load_en`=1. The display never reads `load_data` directly.
- Refresh counter `cnt` counts 0..REFRESH_DIV-1.
- At terminal count (`cnt`==REFRESH_DIV-1):
  - `cnt` wraps to 0.
  - Index `idx` advances by 1 and wraps from NUM_DIGITS-1 to 0.
  - `scan_tick` pulses that cycle.
- With REFRESH_DIV=1, `idx` advances every cycle.
- Output stage is fully registered and recomputed every cycle from the current `idx`, `shadow_data`, `shadow_dp` and `blank_all`:
  - `dec_value` = shadow nibble[idx].
  - `digit_en_n` = ~(1<<idx), or all ones if the digit is blanked.
  - `dp_n` = ~shadow_dp[idx], or 1 if the digit is blanked.
- A digit is blanked when `blank_all`=1, or when leading-zero blanking applies (see Configuration).
- `dec_value` always carries the nibble, including on blanked digits.
- `blank_all` does not stop `cnt` or `idx`. On deassertion, the scan resumes at whatever `idx` has reached.
- No other state exists; there is no FSM beyond `cnt` and `idx`.

## Timing
- Reset (async, immediate on `rst_n` low, including mid-scan):
  - `cnt`=0, `idx`=0, shadows=0.
  - `dec_value`=0, `digit_en_n`=all ones, `dp_n`=1, `scan_tick`=0.
- First clock edge after reset release: `digit_en_n`=~1 (digit 0 lit), `dec_value`=0.
- Load latency: `load_en` sampled at edge N updates the shadows at N; outputs reflect the new data at edge N+1.
- Index latency: `idx` changes at the terminal-count edge T; outputs show the new digit at T+1. Each digit is lit for exactly REFRESH_DIV cycles.
- `load_en` at terminal count: both take effect at the same edge. At the next edge the new `idx` shows the new data.
- `load_en` held high: the shadows reload every cycle.
- `blank_all`: outputs go dark one edge after assertion and return one edge after deassertion.
- `scan_tick` is combinational from `cnt` and is high during the terminal-count cycle.

## Configuration
- Macro `HEX_SCAN_LZB_EN`.
- Defined (leading-zero blanking):
  - `msd` = index of the highest nonzero nibble in `shadow_data`; `msd`=0 if the word is 0.
  - Digit i is blanked when i > `msd`.
  - Digit 0 is never blanked by this rule.
  - `dp` on an LZB-blanked digit is suppressed.
  - `msd` is derived from the registered shadow, so it adds no latency beyond the stated 1 cycle.
- Undefined: no leading-zero blanking; all NUM_DIGITS digits always scan, and only `blank_all` blanks.

## Test plan
All scenarios use NUM_DIGITS=8, REFRESH_DIV=4.

- **Reset mid-scan:** pull `rst_n` low at `idx`=5.
  - Immediately: `digit_en_n`=8'hFF, `dec_value`=0, `dp_n`=1.
  - First edge after release: `digit_en_n`=8'hFE.
- **Full scan:** load 32'h1234ABCD.
  - Digit i shows nibble i for 4 cycles each, with `digit_en_n`=~(1<<i): D,C,B,A,4,3,2,1.
  - `idx` wraps 7 -> 0 after 32 cycles.
  - `scan_tick` pulses every 4th cycle.
- **Leading-zero blanking:** load 32'h000000A0.
  - With macro: digits 0 and 1 lit showing 0 and A; slots 2..7 give `digit_en_n`=8'hFF.
  - Without macro: all 8 digits are lit, showing 0,A,0,0,0,0,0,0.
- **Zero word with decimal point:** load 32'h0 with `dp_sel`=8'h81 and the macro on.
  - Digit 0 lit showing 0 with `dp_n`=0.
  - Slot 7 is dark with `dp_n`=1.
- **Load at terminal count:** assert `load_en` with 32'hFFFFFFFF on the cycle `cnt`=3, `idx`=2.
  - Next edge: `digit_en_n`=~8'h08, `dec_value`=F.
- **Blank during scan:** assert `blank_all` for 6 cycles starting at `idx`=1, `cnt`=0.
  - Outputs are dark from the next edge on.
  - The scan keeps running; on release the display resumes at `idx`=2, `cnt`=2.
